// File: rtl/ifu_stream.sv
// Pipelined instruction fetch unit: issues word-aligned fetches over a
// valid/ready request port, buffers in-order responses as {pc, data}
// pairs and supports redirect with discard of stale responses.
//
// state | meaning
// IDLE  | no new requests issued; responses and drain continue
// RUN   | issue requests while buffer credits remain
module ifu_stream #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 'h8000_0000,
  parameter int                   DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ISA_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [ISA_WIDTH-1:0] mem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ISA_WIDTH-1:0] inst_pc,
  output logic [ISA_WIDTH-1:0] inst_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [ISA_WIDTH-1:0] PC_STEP = ISA_WIDTH'(4);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ISA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ISA_WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [ISA_WIDTH-1:0] fifo_data_q [DEPTH];

  logic                 req_fire;
  logic                 push;
  logic                 pop;
  logic [CW:0]          credit_used;
  logic [ISA_WIDTH-1:0] redirect_aligned;
  logic                 unused_redirect_lsb;

  // Issue is credit-limited so every accepted request has a buffer slot.
  always_comb begin
    credit_used      = {1'b0, count_q} + {1'b0, inflight_q};
    mem_req_valid    = (state_q == RUN) && (credit_used < {1'b0, DEPTH_C});
    mem_req_addr     = fetch_pc_q;
    req_fire         = mem_req_valid && mem_req_ready;
    inst_valid       = (count_q != '0) && !redirect_valid;
    pop              = inst_valid && inst_ready;
    push             = mem_rsp_valid && (drop_q == '0) && !redirect_valid;
    redirect_aligned = {redirect_pc[ISA_WIDTH-1:2], 2'b00};
    inst_pc          = fifo_pc_q[rd_ptr_q];
    inst_data        = fifo_data_q[rd_ptr_q];
  end

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-state logic: fetch_en alone moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en)  state_d = RUN;
      RUN:  if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, pointer and PC updates; redirect overrides everything.
  always_comb begin
    inflight_d = inflight_q + {{(CW-1){1'b0}}, req_fire}
                            - {{(CW-1){1'b0}}, mem_rsp_valid};
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect_valid) begin
      // Everything still outstanding after this edge is stale.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_d     = inflight_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (mem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Instruction buffer storage; cleared so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

  // Credit accounting must never let a response land in a full buffer.
  always_ff @(posedge clk) begin
    if (rst && push) assert (count_q != DEPTH_C);
  end

endmodule

// File: tb/tb_ifu_stream.sv
// Directed bench for ifu_stream: a behavioural memory with configurable
// latency answers requests in order with data = ~address.
module tb_ifu_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  logic [31:0] issued[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  ifu_stream dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst_data     (inst_data)
  );

  always #5 clk = ~clk;

  // One cycle: sample at negedge, advance memory model just after posedge.
  task automatic step();
    logic        fire_s;
    logic [31:0] addr_s;
    @(negedge clk);
    fire_s = mem_req_valid && mem_req_ready;
    addr_s = mem_req_addr;
    if (fire_s) issued.push_back(addr_s);
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_data.push_back(inst_data);
    end
    @(posedge clk);
    cyc++;
    if (fire_s) begin
      pend_addr.push_back(addr_s);
      pend_due.push_back(cyc + lat);
    end
    #1;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc + 1) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = ~pend_addr[0];
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  task automatic clear_log();
    issued.delete();
    got_pc.delete();
    got_data.delete();
  endtask

  task automatic drain();
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    repeat (14) step();
    clear_log();
  endtask

  task automatic set_pc(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_req_addr got %h exp 80000000", mem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    checks++; if ({inst_pc, inst_data} !== 64'h0) begin errors++; $display("FAIL reset_inst_pc_data got %h_%h exp 0_0", inst_pc, inst_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b exp 0", mem_req_valid); end
  endtask

  task automatic test_stream();
    lat = 1; inst_ready = 1'b1; clear_log();
    fetch_en = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stream_not_yet got %b exp 0", mem_req_valid); end
    step();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid got %b exp 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stream_first_addr got %h exp 80000000", mem_req_addr); end
    repeat (11) step();
    checks++; if (issued.size() !== 11) begin errors++; $display("FAIL stream_issue_count got %0d exp 11", issued.size()); end
    checks++; if (issued[3] !== 32'h8000_000C) begin errors++; $display("FAIL stream_addr3 got %h exp 8000000c", issued[3]); end
    checks++; if (got_pc.size() !== 9) begin errors++; $display("FAIL stream_deliver_count got %0d exp 9", got_pc.size()); end
    checks++; if (got_pc[0] !== 32'h8000_0000) begin errors++; $display("FAIL stream_pc0 got %h exp 80000000", got_pc[0]); end
    checks++; if (got_pc[8] !== 32'h8000_0020) begin errors++; $display("FAIL stream_pc8 got %h exp 80000020", got_pc[8]); end
    checks++; if (got_data[8] !== 32'h7FFF_FFDF) begin errors++; $display("FAIL stream_data8 got %h exp 7fffffdf", got_data[8]); end
    drain();
  endtask

  task automatic test_backpressure();
    lat = 1;
    set_pc(32'h8000_0100);
    clear_log();
    inst_ready = 1'b0; fetch_en = 1'b1;
    repeat (15) step();
    checks++; if (issued.size() !== 4) begin errors++; $display("FAIL bp_issue_cap got %0d exp 4", issued.size()); end
    checks++; if (issued[3] !== 32'h8000_010C) begin errors++; $display("FAIL bp_addr3 got %h exp 8000010c", issued[3]); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled got %b exp 0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin errors++; $display("FAIL bp_head got %b/%h exp 1/80000100", inst_valid, inst_pc); end
    clear_log();
    inst_ready = 1'b1;
    repeat (4) step();
    checks++; if (got_pc.size() !== 4 || got_pc[3] !== 32'h8000_010C) begin errors++; $display("FAIL bp_release_order got %0d/%h exp 4/8000010c", got_pc.size(), got_pc[3]); end
    checks++; if (issued.size() !== 3 || issued[0] !== 32'h8000_0110) begin errors++; $display("FAIL bp_resume got %0d/%h exp 3/80000110", issued.size(), issued[0]); end
    drain();
  endtask

  task automatic test_flush();
    lat = 1;
    set_pc(32'h8000_0500);
    clear_log();
    inst_ready = 1'b0; fetch_en = 1'b1;
    repeat (10) step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b exp 1", inst_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0600;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_mask_valid got %b exp 0", inst_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b exp 0", inst_valid); end
    checks++; if (mem_req_addr !== 32'h8000_0600) begin errors++; $display("FAIL flush_addr got %h exp 80000600", mem_req_addr); end
    clear_log();
    inst_ready = 1'b1;
    repeat (5) step();
    checks++; if (got_pc[0] !== 32'h8000_0600) begin errors++; $display("FAIL flush_first_pc got %h exp 80000600", got_pc[0]); end
    drain();
  endtask

  task automatic test_redirect_latency();
    lat = 3;
    set_pc(32'h8000_0200);
    clear_log();
    inst_ready = 1'b1; fetch_en = 1'b1;
    repeat (4) step();
    checks++; if (issued.size() !== 3) begin errors++; $display("FAIL rl_inflight got %0d exp 3", issued.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (dut.drop_q !== 3'd3) begin errors++; $display("FAIL rl_drop got %0d exp 3", dut.drop_q); end
    checks++; if (mem_req_addr !== 32'h8000_1000) begin errors++; $display("FAIL rl_addr got %h exp 80001000", mem_req_addr); end
    clear_log();
    repeat (10) step();
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL rl_deliver_count got %0d exp >=2", got_pc.size()); end
    checks++; if (got_pc[0] !== 32'h8000_1000) begin errors++; $display("FAIL rl_pc0 got %h exp 80001000", got_pc[0]); end
    checks++; if (got_pc[1] !== 32'h8000_1004) begin errors++; $display("FAIL rl_pc1 got %h exp 80001004", got_pc[1]); end
    checks++; if (got_data[0] !== 32'h7FFF_EFFF) begin errors++; $display("FAIL rl_data0 got %h exp 7fffefff", got_data[0]); end
    drain();
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1;
    set_pc(32'h8000_0300);
    clear_log();
    inst_ready = 1'b1; fetch_en = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    #1;
    checks++; if ({mem_req_valid, mem_rsp_valid} !== 2'b11) begin errors++; $display("FAIL sc_setup got %b exp 11", {mem_req_valid, mem_rsp_valid}); end
    step();
    redirect_valid = 1'b0;
    checks++; if (dut.drop_q !== 3'd1) begin errors++; $display("FAIL sc_drop got %0d exp 1", dut.drop_q); end
    checks++; if (dut.inflight_q !== 3'd1) begin errors++; $display("FAIL sc_inflight got %0d exp 1", dut.inflight_q); end
    clear_log();
    repeat (6) step();
    checks++; if (got_pc[0] !== 32'h8000_0400) begin errors++; $display("FAIL sc_first_pc got %h exp 80000400", got_pc[0]); end
    drain();
  endtask

  task automatic test_wrap();
    lat = 1;
    set_pc(32'hFFFF_FFF8);
    clear_log();
    inst_ready = 1'b1; fetch_en = 1'b1;
    repeat (8) step();
    checks++; if (issued[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1 got %h exp fffffffc", issued[1]); end
    checks++; if (issued[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr2 got %h exp 00000000", issued[2]); end
    checks++; if (got_pc[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffff8", got_pc[0]); end
    checks++; if (got_pc[2] !== 32'h0 || got_data[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pc2 got %h/%h exp 00000000/ffffffff", got_pc[2], got_data[2]); end
    drain();
  endtask

  task automatic test_fetch_en_low();
    lat = 3;
    set_pc(32'h8000_0700);
    clear_log();
    inst_ready = 1'b1; fetch_en = 1'b1;
    repeat (2) step();
    fetch_en = 1'b0;
    repeat (9) step();
    checks++; if (issued.size() !== 2) begin errors++; $display("FAIL en_low_issue got %0d exp 2", issued.size()); end
    checks++; if (got_pc.size() !== 2 || got_pc[1] !== 32'h8000_0704) begin errors++; $display("FAIL en_low_deliver got %0d/%h exp 2/80000704", got_pc.size(), got_pc[1]); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL en_low_req got %b exp 0", mem_req_valid); end
  endtask

  task automatic test_reset_mid();
    lat = 1;
    clear_log();
    inst_ready = 1'b0; fetch_en = 1'b1;
    repeat (6) step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", inst_valid); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rm_req got %b/%h exp 0/80000000", mem_req_valid, mem_req_addr); end
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL rm_inst got %b/%h/%h exp 0/0/0", inst_valid, inst_pc, inst_data); end
    fetch_en = 1'b0;
    mem_rsp_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rm_after got %b/%b exp 0/0", mem_req_valid, inst_valid); end
  endtask

  initial begin
    fetch_en       = 1'b0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_redirect_latency();
    test_redirect_same_cycle();
    test_wrap();
    test_fetch_en_low();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
